// File: rtl/misr_pkg.sv
// Shared types, constants and the MISR next-state function
// for the 32-bit signature compactor.
package misr_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  localparam logic [WIDTH-1:0] MISR_TAPS_S35932 = 32'h0000_8409;

  typedef enum logic [2:0] {
    IDLE,
    COMPACT,
    CMP,
    UNLOAD,
    DONE
  } state_e;

  function automatic logic [WIDTH-1:0] misr_next(
    input logic [WIDTH-1:0] sig,
    input logic [WIDTH-1:0] din,
    input logic [WIDTH-1:0] taps = MISR_TAPS_S35932
  );
    logic [WIDTH-1:0] fb;
    fb = sig[WIDTH-1] ? taps : '0;
    return {sig[WIDTH-2:0], 1'b0} ^ fb ^ din;
  endfunction

endpackage

// File: rtl/misr32_sig_compactor_if.sv
// Control, data and status bundle between the compactor
// and whatever drives it (BIST controller or bench).
interface misr32_sig_compactor_if
  import misr_pkg::*;
;
  logic             start;
  logic [CNT_W-1:0] win_len;
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] golden;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] sig;
  logic             so;

  modport master (
    output start, win_len, din_valid, din, golden,
    input  busy, done, pass, sig, so
  );

  modport slave (
    input  start, win_len, din_valid, din, golden,
    output busy, done, pass, sig, so
  );

endinterface

// File: rtl/misr32_core.sv
// Signature register with seed load and MISR fold enable.
// Load wins over enable.
module misr32_core
  import misr_pkg::*;
#(
  parameter logic [WIDTH-1:0] TAPS = MISR_TAPS_S35932,
  parameter logic [WIDTH-1:0] SEED = '0
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= misr_next(sig, din, TAPS);
    end
  end

endmodule

// File: rtl/misr32_sig_compactor.sv
// Window control, golden compare and MSB-first serial unload
// around the MISR core.
module misr32_sig_compactor
  import misr_pkg::*;
#(
  parameter logic [WIDTH-1:0] TAPS = MISR_TAPS_S35932,
  parameter logic [WIDTH-1:0] SEED = '0
) (
  input logic                   ck,
  input logic                   reset,
  misr32_sig_compactor_if.slave bus
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic [WIDTH-1:0] shreg;
  logic [4:0]       bitcnt;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [WIDTH-1:0] sig;
  logic             idle_like;
  logic             load;
  logic             en;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign load      = idle_like && bus.start;
  // Once cnt reaches len the window is full; extra words are dropped.
  assign en        = (state == COMPACT) && bus.din_valid && (cnt != len);

  misr32_core #(
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_core (
    .ck    (ck),
    .reset (reset),
    .load  (load),
    .en    (en),
    .din   (bus.din),
    .sig   (sig)
  );

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      len    <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            cnt    <= '0;
            len    <= bus.win_len;
            pass_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= (bus.win_len == '0) ? CMP : COMPACT;
          end
        end
        COMPACT: begin
          if (cnt == len) begin
            state <= CMP;
          end else if (bus.din_valid) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CMP: begin
          pass_q <= (sig == bus.golden);
          shreg  <= sig;
          bitcnt <= '0;
          state  <= UNLOAD;
        end
        UNLOAD: begin
          shreg  <= {shreg[WIDTH-2:0], 1'b0};
          bitcnt <= bitcnt + 5'd1;
          if (bitcnt == 5'd31) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.sig  = sig;
  assign bus.so   = shreg[WIDTH-1];

endmodule
